// File: rtl/popcnt_accum.sv
// Two-stage population-count accumulator: S1 counts one beat, S2 sums beats until s_last and emits a total.
// Define POPCNT_SATURATE_EN to clamp the total at all-ones instead of wrapping; m_ovf is the same in both builds.
module popcnt_accum #(
  parameter  int IN_W  = 11,
  parameter  int ACC_W = 16,
  localparam int CNT_W = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data,
  output logic             m_ovf
);

  localparam int SUM_W = ACC_W + 1;

  logic             v1_q, v1_d;
  logic             last1_q, last1_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             m_valid_q, m_valid_d;
  logic [ACC_W-1:0] m_data_q, m_data_d;
  logic             m_ovf_q, m_ovf_d;

  logic             stall;
  logic             s_hs;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] d);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IN_W; i++) c = c + CNT_W'(d[i]);
    return c;
  endfunction

  // A held result freezes both stages; S1 may still fill if it is empty.
  assign stall   = m_valid_q && !m_ready;
  assign s_ready = !v1_q || !stall;
  assign s_hs    = s_valid && s_ready;

  assign sum      = {1'b0, acc_q} + SUM_W'(cnt1_q);
  assign ovf_next = ovf_q | sum[ACC_W];
`ifdef POPCNT_SATURATE_EN
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_comb begin
    // NOTE: every _d starts from its held value so no branch can leave one unassigned and infer a latch.
    v1_d      = v1_q;
    last1_d   = last1_q;
    cnt1_d    = cnt1_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (v1_q && !stall) begin
      if (last1_q) begin
        // A completing vector overrides the accept-clear above, giving zero-bubble hand-over.
        m_data_d  = acc_next;
        m_ovf_d   = ovf_next;
        m_valid_d = 1'b1;
        acc_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        acc_d = acc_next;
        ovf_d = ovf_next;
      end
    end

    if (s_hs) begin
      v1_d    = 1'b1;
      cnt1_d  = popcount(s_data);
      last1_d = s_last;
    end else if (!stall) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      cnt1_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      cnt1_q    <= cnt1_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: a 16-bit and an 8-bit accumulator driven with the same beats.
module tb_popcnt_accum;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [10:0] s_data;
  logic        s_last;
  logic        m_ready;

  logic        a_s_ready, a_m_valid, a_m_ovf;
  logic [15:0] a_m_data;
  logic        b_s_ready, b_m_valid, b_m_ovf;
  logic [7:0]  b_m_data;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          cyc;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  int   cyc;
  int   total;
  int   bad;

`ifdef POPCNT_SATURATE_EN
  localparam int OVF8_EXP = 255;
`else
  localparam int OVF8_EXP = 8;
`endif

  popcnt_accum #(.IN_W(11), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_ovf(a_m_ovf)
  );

  popcnt_accum #(.IN_W(11), .ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_ovf(b_m_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Results are captured half a cycle before the edge that completes their handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_m_valid && m_ready) qa.push_back('{32'(a_m_data), a_m_ovf, cyc});
      if (b_m_valid && m_ready) qb.push_back('{32'(b_m_data), b_m_ovf, cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pop_a(input string tag, input int d, input int o);
    res_t r;
    if (qa.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      r = qa.pop_front();
      check({tag, "_data"}, r.data, d);
      check({tag, "_ovf"}, 32'(r.ovf), o);
    end
  endtask

  task automatic pop_b(input string tag, input int d, input int o);
    res_t r;
    if (qb.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      r = qb.pop_front();
      check({tag, "_data"}, r.data, d);
      check({tag, "_ovf"}, 32'(r.ovf), o);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a beat and returns 1 time unit after the edge that accepts it.
  task automatic send_beat(input logic [10:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!a_s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(a_s_ready), 1);
    check({tag, "_m_valid"}, 32'(a_m_valid), 0);
    check({tag, "_m_data"},  32'(a_m_data), 0);
    check({tag, "_m_ovf"},   32'(a_m_ovf), 0);
    check({tag, "_b_m_valid"}, 32'(b_m_valid), 0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    m_ready = 1'b1;
    idle();
    #3;
    check_reset_outputs("init_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);

    // Single-beat vector and its two-cycle latency.
    send_beat(11'h7FF, 1'b1);
    check("lat_early_m_valid", 32'(a_m_valid), 0);
    idle();
    @(posedge clk);
    #1;
    check("lat_m_valid", 32'(a_m_valid), 1);
    check("lat_m_data", 32'(a_m_data), 11);
    wait_cycles(2);
    pop_a("single", 11, 0);
    check("single_count", qa.size(), 0);
    qb.delete();

    // Three-beat vector gives one pulse.
    send_beat(11'h7FF, 1'b0);
    send_beat(11'h001, 1'b0);
    send_beat(11'h555, 1'b1);
    idle();
    wait_cycles(4);
    check("three_count", qa.size(), 1);
    pop_a("three", 18, 0);
    qb.delete();

    // Backpressure: a held result lets exactly one more beat into S1.
    m_ready = 1'b0;
    send_beat(11'h00F, 1'b1);
    send_beat(11'h0FF, 1'b1);
    s_valid = 1'b1;
    s_data  = 11'h001;
    s_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_s_ready_%0d", i), 32'(a_s_ready), 0);
      check($sformatf("bp_m_valid_%0d", i), 32'(a_m_valid), 1);
      check($sformatf("bp_m_data_%0d", i), 32'(a_m_data), 4);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send_beat(11'h001, 1'b1);
    idle();
    wait_cycles(4);
    pop_a("bp_first", 4, 0);
    pop_a("bp_second", 8, 0);
    pop_a("bp_third", 1, 0);
    check("bp_count", qa.size(), 0);
    qb.delete();

    // 24 beats of eleven ones: 264 fits in 16 bits but not in 8.
    for (int i = 0; i < 24; i++) send_beat(11'h7FF, (i == 23));
    idle();
    wait_cycles(4);
    pop_a("ovf16", 264, 0);
    pop_b("ovf8", OVF8_EXP, 1);

    // Follow-up vector on the narrow instance starts clean.
    send_beat(11'h003, 1'b1);
    idle();
    wait_cycles(4);
    pop_a("after_ovf16", 2, 0);
    pop_b("after_ovf8", 2, 0);

    // Back-to-back last beats produce results on consecutive cycles.
    send_beat(11'h00F, 1'b1);
    send_beat(11'h0FF, 1'b1);
    idle();
    wait_cycles(4);
    if (qa.size() >= 2) check("b2b_gap", 32'(qa[1].cyc - qa[0].cyc), 1);
    else check("b2b_count", qa.size(), 2);
    pop_a("b2b_first", 4, 0);
    pop_a("b2b_second", 8, 0);
    qb.delete();

    // Reset mid-vector discards the partial sum.
    send_beat(11'h7FF, 1'b0);
    send_beat(11'h7FF, 1'b0);
    idle();
    wait_cycles(1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    wait_cycles(1);
    send_beat(11'h003, 1'b1);
    idle();
    wait_cycles(4);
    pop_a("post_rst", 2, 0);
    pop_b("post_rst_b", 2, 0);
    check("post_rst_count", qa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
